// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag hunt, zero destuffing, LSB-first octet assembly, CRC-16/X.25 check.
// Build option HDLC_RX_FCS_STRIP_EN: hold two octets back so the FCS is never presented on dout.
module hdlc_rx_deframer #(
    parameter int          MAX_BYTES = 16,
    parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_valid,
    input  logic        bit_in,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic        sof,
    output logic        eof,
    output logic        frame_ok,
    output logic        crc_err,
    output logic        abort,
    output logic [7:0]  byte_count,
    output logic [31:0] frame_counter,
    output logic [31:0] err_counter
);
    typedef enum logic {HUNT, DATA} state_t;
    localparam logic [7:0] MAXB = 8'(MAX_BYTES);

    state_t      r_state;
    logic [7:0]  r_win;
    logic [3:0]  r_fill;
    logic [2:0]  r_rones;
    logic [2:0]  r_dones;
    logic [7:0]  r_oct;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_bytes;
    logic [15:0] r_crc;
`ifdef HDLC_RX_FCS_STRIP_EN
    logic [7:0]  r_h0, r_h1;
    logic [1:0]  r_hsof;
    logic [1:0]  r_hcnt;
`endif

    logic [7:0]  w_win, w_oct, w_bytes_n;
    logic [3:0]  w_fill;
    logic [2:0]  w_rones, w_dones_n, w_bits_n;
    logic [15:0] w_crc_n;
    logic        w_exit_vld, w_exit, w_flag, w_abort, w_take, w_drop;
    logic        w_done, w_ovf, w_nonempty, w_good;

    always_comb begin
        w_win      = {bit_in, r_win[7:1]};
        w_exit_vld = (r_fill == 4'd8);
        w_exit     = r_win[0];
        w_fill     = w_exit_vld ? 4'd8 : r_fill + 4'd1;
        w_flag     = (w_win == 8'h7E) && (w_fill == 4'd8);
        w_abort    = bit_in && (r_rones == 3'd6);
        w_rones    = !bit_in ? 3'd0 : (r_rones == 3'd7) ? 3'd7 : r_rones + 3'd1;
        // A zero following five ones on the exit side is a stuffed bit.
        w_drop     = (r_state == DATA) && w_exit_vld && !w_exit && (r_dones == 3'd5);
        w_take     = (r_state == DATA) && w_exit_vld && !w_drop;
        w_oct      = {w_exit, r_oct[7:1]};
        w_done     = w_take && (r_bitcnt == 3'd7);
        w_bits_n   = w_take ? r_bitcnt + 3'd1 : r_bitcnt;
        w_bytes_n  = w_done ? r_bytes + 8'd1 : r_bytes;
        w_ovf      = w_done && (r_bytes == MAXB);
        w_dones_n  = r_dones;
        if (w_drop)
            w_dones_n = 3'd0;
        else if (w_take)
            w_dones_n = !w_exit ? 3'd0 : (r_dones == 3'd7) ? 3'd7 : r_dones + 3'd1;
        w_crc_n = r_crc;
        if (w_take)
            w_crc_n = {1'b0, r_crc[15:1]} ^ ((r_crc[0] ^ w_exit) ? 16'h8408 : 16'h0000);
        w_nonempty = (w_bytes_n != 8'd0) || (w_bits_n != 3'd0);
        w_good     = (w_bits_n == 3'd0) && (w_bytes_n >= 8'd3) && (w_crc_n == 16'hF0B8);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= HUNT;
            r_win         <= '0;
            r_fill        <= '0;
            r_rones       <= '0;
            r_dones       <= '0;
            r_oct         <= '0;
            r_bitcnt      <= '0;
            r_bytes       <= '0;
            r_crc         <= CRC_INIT;
            dout          <= '0;
            dout_valid    <= 1'b0;
            sof           <= 1'b0;
            eof           <= 1'b0;
            frame_ok      <= 1'b0;
            crc_err       <= 1'b0;
            abort         <= 1'b0;
            byte_count    <= '0;
            frame_counter <= '0;
            err_counter   <= '0;
`ifdef HDLC_RX_FCS_STRIP_EN
            r_h0          <= '0;
            r_h1          <= '0;
            r_hsof        <= '0;
            r_hcnt        <= '0;
`endif
        end else begin
            dout_valid <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            frame_ok   <= 1'b0;
            crc_err    <= 1'b0;
            abort      <= 1'b0;
            if (bit_valid) begin
                r_win   <= w_win;
                r_fill  <= w_flag ? 4'd0 : w_fill;
                r_rones <= w_rones;
                if (w_abort) begin
                    r_win   <= '0;
                    r_fill  <= '0;
                    r_state <= HUNT;
                    if (r_state == DATA) begin
                        abort <= 1'b1;
                        if (r_bytes != 8'd0 || r_bitcnt != 3'd0)
                            err_counter <= err_counter + 32'd1;
                    end
                end else if (r_state == HUNT) begin
                    if (w_flag) begin
                        r_state  <= DATA;
                        r_crc    <= CRC_INIT;
                        r_bytes  <= '0;
                        r_bitcnt <= '0;
                        r_dones  <= '0;
`ifdef HDLC_RX_FCS_STRIP_EN
                        r_hcnt   <= '0;
`endif
                    end
                end else begin
                    r_bitcnt <= w_bits_n;
                    r_bytes  <= w_bytes_n;
                    r_dones  <= w_dones_n;
                    r_crc    <= w_crc_n;
                    if (w_take)
                        r_oct <= w_oct;
                    if (w_ovf) begin
                        abort       <= 1'b1;
                        err_counter <= err_counter + 32'd1;
                        r_state     <= HUNT;
                    end else if (w_done) begin
                        byte_count <= w_bytes_n;
`ifdef HDLC_RX_FCS_STRIP_EN
                        case (r_hcnt)
                            2'd0: begin
                                r_h0      <= w_oct;
                                r_hsof[0] <= (r_bytes == 8'd0);
                                r_hcnt    <= 2'd1;
                            end
                            2'd1: begin
                                r_h1      <= w_oct;
                                r_hsof[1] <= (r_bytes == 8'd0);
                                r_hcnt    <= 2'd2;
                            end
                            default: begin
                                dout       <= r_h0;
                                dout_valid <= 1'b1;
                                sof        <= r_hsof[0];
                                r_h0       <= r_h1;
                                r_hsof[0]  <= r_hsof[1];
                                r_h1       <= w_oct;
                                r_hsof[1]  <= (r_bytes == 8'd0);
                            end
                        endcase
`else
                        dout       <= w_oct;
                        dout_valid <= 1'b1;
                        sof        <= (r_bytes == 8'd0);
`endif
                    end
                    // A flag landing with an overflow still opens the next frame.
                    if (w_flag) begin
                        r_state <= DATA;
                        if (!w_ovf && w_nonempty) begin
                            eof <= 1'b1;
                            if (w_good) begin
                                frame_ok      <= 1'b1;
                                frame_counter <= frame_counter + 32'd1;
                            end else begin
                                crc_err     <= 1'b1;
                                err_counter <= err_counter + 32'd1;
                            end
                        end
                        r_crc    <= CRC_INIT;
                        r_bytes  <= '0;
                        r_bitcnt <= '0;
                        r_dones  <= '0;
`ifdef HDLC_RX_FCS_STRIP_EN
                        r_hcnt   <= '0;
`endif
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Directed bench for hdlc_rx_deframer: stuffed bit streams in, octets/status/counters checked.
module tb_hdlc_rx_deframer;
    logic        clk = 1'b0, rst_n = 1'b0, bit_valid = 1'b0, bit_in = 1'b0;
    logic [7:0]  dout, byte_count;
    logic        dout_valid, sof, eof, frame_ok, crc_err, abort;
    logic [31:0] frame_counter, err_counter;

    always #5 clk = ~clk;

    hdlc_rx_deframer dut (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
        .dout(dout), .dout_valid(dout_valid), .sof(sof), .eof(eof),
        .frame_ok(frame_ok), .crc_err(crc_err), .abort(abort),
        .byte_count(byte_count), .frame_counter(frame_counter), .err_counter(err_counter)
    );

    int vec = 0, miss = 0;
    int ones = 0;
    bit gap = 1'b0;

    logic [7:0] rx_q[$];
    int sof_idx[$];
    int n_eof = 0, n_ok = 0, n_cerr = 0, n_abort = 0, n_eofdv = 0;

    always @(negedge clk) if (rst_n) begin
        if (dout_valid) begin
            if (sof) sof_idx.push_back(rx_q.size());
            rx_q.push_back(dout);
        end
        if (eof) begin
            n_eof++;
            if (frame_ok) n_ok++;
            if (crc_err) n_cerr++;
            if (dout_valid) n_eofdv++;
        end
        if (abort) n_abort++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] fcs(input logic [7:0] q[$]);
        logic [15:0] c = 16'hFFFF;
        foreach (q[k])
            for (int i = 0; i < 8; i++)
                c = (c[0] ^ q[k][i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        return ~c;
    endfunction

    task automatic send_bit(input logic b);
        bit_valid = 1'b1; bit_in = b;
        @(posedge clk); #1;
        bit_valid = 1'b0; bit_in = 1'b0;
        if (gap) begin
            bit_in = 1'b1;
            @(posedge clk); #1;
            bit_in = 1'b0;
        end
    endtask

    task automatic send_sbit(input logic b);
        send_bit(b);
        if (b) begin
            ones++;
            if (ones == 5) begin send_bit(1'b0); ones = 0; end
        end else ones = 0;
    endtask

    task automatic send_flag();
        logic [7:0] f = 8'h7E;
        for (int i = 0; i < 8; i++) send_bit(f[i]);
        ones = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_sbit(b[i]);
    endtask

    task automatic send_frame(input logic [7:0] q[$], input bit add_fcs);
        logic [15:0] f;
        foreach (q[k]) send_byte(q[k]);
        if (add_fcs) begin
            f = fcs(q);
            send_byte(f[7:0]);
            send_byte(f[15:8]);
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
        repeat (3) @(posedge clk);
        #1; bit_valid = 1'b0; bit_in = 1'b0;
        vec++; if ({dout, dout_valid, sof, eof, frame_ok, crc_err, abort, byte_count} !== 22'h0) begin
            miss++; $display("FAIL reset_outputs: got %h want 0", {dout, dout_valid, sof, eof, frame_ok, crc_err, abort, byte_count}); end
        vec++; if (frame_counter !== 32'd0) begin miss++; $display("FAIL reset_frame_counter: got %0d want 0", frame_counter); end
        vec++; if (err_counter !== 32'd0) begin miss++; $display("FAIL reset_err_counter: got %0d want 0", err_counter); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] q[$];
        logic [7:0] exp[$];
        int b_rx = rx_q.size(), b_sof = sof_idx.size(), b_eof = n_eof, b_ok = n_ok, b_dv = n_eofdv;
        q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
        exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
`ifndef HDLC_RX_FCS_STRIP_EN
        exp.push_back(8'h6E); exp.push_back(8'h90);
`endif
        repeat (3) send_bit(1'b1);
        send_flag(); send_frame(q, 1'b0); send_flag(); settle();
        vec++; if (rx_q.size() - b_rx !== exp.size()) begin miss++; $display("FAIL basic_count: got %0d want %0d", rx_q.size() - b_rx, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            vec++; if (b_rx + i >= rx_q.size() || rx_q[b_rx + i] !== exp[i]) begin
                miss++; $display("FAIL basic_dout[%0d]: got %h want %h", i, (b_rx + i < rx_q.size()) ? rx_q[b_rx + i] : 8'hxx, exp[i]); end
        end
        vec++; if (sof_idx.size() - b_sof !== 1 || sof_idx[b_sof] !== b_rx) begin miss++; $display("FAIL basic_sof: got %0d sof pulses want 1 at first octet", sof_idx.size() - b_sof); end
        vec++; if (n_eof - b_eof !== 1 || n_ok - b_ok !== 1) begin miss++; $display("FAIL basic_eof_ok: got eof %0d ok %0d want 1 1", n_eof - b_eof, n_ok - b_ok); end
        vec++; if (n_eofdv - b_dv !== 1) begin miss++; $display("FAIL basic_eof_with_dv: got %0d want 1", n_eofdv - b_dv); end
        vec++; if (byte_count !== 8'd11) begin miss++; $display("FAIL basic_byte_count: got %0d want 11", byte_count); end
        vec++; if (frame_counter !== 32'd1) begin miss++; $display("FAIL basic_frame_counter: got %0d want 1", frame_counter); end
    endtask

    task automatic test_transparency();
        logic [7:0] q[$];
        logic [7:0] exp[$];
        logic [15:0] f;
        int b_rx = rx_q.size(), b_eof = n_eof, b_ok = n_ok;
        q = '{8'hFF, 8'h7E, 8'h3F};
        exp = q;
`ifndef HDLC_RX_FCS_STRIP_EN
        f = fcs(q); exp.push_back(f[7:0]); exp.push_back(f[15:8]);
`endif
        gap = 1'b1;
        send_flag(); send_frame(q, 1'b1); send_flag();
        gap = 1'b0; settle();
        vec++; if (rx_q.size() - b_rx !== exp.size()) begin miss++; $display("FAIL transp_count: got %0d want %0d", rx_q.size() - b_rx, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            vec++; if (b_rx + i >= rx_q.size() || rx_q[b_rx + i] !== exp[i]) begin
                miss++; $display("FAIL transp_dout[%0d]: got %h want %h", i, (b_rx + i < rx_q.size()) ? rx_q[b_rx + i] : 8'hxx, exp[i]); end
        end
        vec++; if (n_eof - b_eof !== 1 || n_ok - b_ok !== 1) begin miss++; $display("FAIL transp_eof_ok: got eof %0d ok %0d want 1 1", n_eof - b_eof, n_ok - b_ok); end
        vec++; if (frame_counter !== 32'd2) begin miss++; $display("FAIL transp_frame_counter: got %0d want 2", frame_counter); end
    endtask

    task automatic test_crc_err();
        logic [7:0] q[$];
        logic [7:0] empty[$];
        int b_eof = n_eof, b_ok = n_ok, b_ce = n_cerr;
        q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6F, 8'h90};
        send_flag(); send_frame(q, 1'b0); send_flag(); settle();
        vec++; if (n_eof - b_eof !== 1 || n_ok - b_ok !== 0 || n_cerr - b_ce !== 1) begin
            miss++; $display("FAIL crc_bad_fcs: got eof %0d ok %0d crc_err %0d want 1 0 1", n_eof - b_eof, n_ok - b_ok, n_cerr - b_ce); end
        vec++; if (err_counter !== 32'd1 || frame_counter !== 32'd2) begin
            miss++; $display("FAIL crc_counters: got err %0d frames %0d want 1 2", err_counter, frame_counter); end
        // Two octets with a valid residue: still a runt.
        b_ce = n_cerr;
        send_frame(empty, 1'b1); send_flag(); settle();
        vec++; if (n_cerr - b_ce !== 1 || err_counter !== 32'd2) begin
            miss++; $display("FAIL crc_runt: got crc_err %0d err %0d want 1 2", n_cerr - b_ce, err_counter); end
        b_ce = n_cerr;
        q = '{8'h41, 8'h42, 8'h43};
        send_frame(q, 1'b1); send_sbit(1'b0); send_sbit(1'b1); send_sbit(1'b0); send_flag(); settle();
        vec++; if (n_cerr - b_ce !== 1 || err_counter !== 32'd3 || n_ok !== b_ok) begin
            miss++; $display("FAIL crc_unaligned: got crc_err %0d err %0d ok %0d want 1 3 %0d", n_cerr - b_ce, err_counter, n_ok, b_ok); end
    endtask

    task automatic test_abort();
        logic [7:0] q[$];
        int b_ab = n_abort, b_eof = n_eof, b_ok = n_ok;
        send_flag(); send_byte(8'h31); send_byte(8'h32);
        repeat (8) send_bit(1'b1);
        settle();
        vec++; if (n_abort - b_ab !== 1 || n_eof - b_eof !== 0) begin
            miss++; $display("FAIL abort_pulse: got abort %0d eof %0d want 1 0", n_abort - b_ab, n_eof - b_eof); end
        vec++; if (err_counter !== 32'd4) begin miss++; $display("FAIL abort_err_counter: got %0d want 4", err_counter); end
        q = '{8'h61, 8'h62};
        send_flag(); send_frame(q, 1'b1); send_flag(); settle();
        vec++; if (n_ok - b_ok !== 1 || frame_counter !== 32'd3) begin
            miss++; $display("FAIL abort_recover: got ok %0d frames %0d want 1 3", n_ok - b_ok, frame_counter); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        int b_rx = rx_q.size(), b_sof = sof_idx.size(), b_eof = n_eof, b_ok = n_ok;
        int exp_n;
        qa = '{8'h41, 8'h42, 8'h43};
        qb = '{8'h51, 8'h52, 8'h53, 8'h54};
`ifdef HDLC_RX_FCS_STRIP_EN
        exp_n = 7;
`else
        exp_n = 11;
`endif
        send_flag(); send_flag(); send_flag();
        send_frame(qa, 1'b1); send_flag(); send_frame(qb, 1'b1); send_flag(); settle();
        vec++; if (rx_q.size() - b_rx !== exp_n) begin miss++; $display("FAIL b2b_count: got %0d want %0d", rx_q.size() - b_rx, exp_n); end
        vec++; if (b_rx >= rx_q.size() || rx_q[b_rx] !== 8'h41) begin miss++; $display("FAIL b2b_first: got %h want 41", (b_rx < rx_q.size()) ? rx_q[b_rx] : 8'hxx); end
        vec++; if (sof_idx.size() - b_sof !== 2) begin miss++; $display("FAIL b2b_sof: got %0d want 2", sof_idx.size() - b_sof); end
        vec++; if (n_eof - b_eof !== 2 || n_ok - b_ok !== 2 || frame_counter !== 32'd5) begin
            miss++; $display("FAIL b2b_eof_ok: got eof %0d ok %0d frames %0d want 2 2 5", n_eof - b_eof, n_ok - b_ok, frame_counter); end
    endtask

    task automatic test_overflow();
        logic [7:0] q[$];
        int b_rx, b_ab, b_eof, b_ok = n_ok;
        int exp_n;
        logic [7:0] exp_last;
        for (int i = 1; i <= 14; i++) q.push_back(8'(i));
        send_flag(); send_frame(q, 1'b1); send_flag(); settle();
        vec++; if (n_ok - b_ok !== 1 || frame_counter !== 32'd6 || byte_count !== 8'd16) begin
            miss++; $display("FAIL max_len_frame: got ok %0d frames %0d bytes %0d want 1 6 16", n_ok - b_ok, frame_counter, byte_count); end
        q.delete();
        for (int i = 0; i < 17; i++) q.push_back(8'(8'h10 + i));
`ifdef HDLC_RX_FCS_STRIP_EN
        exp_n = 14; exp_last = 8'h1D;
`else
        exp_n = 16; exp_last = 8'h1F;
`endif
        b_rx = rx_q.size(); b_ab = n_abort; b_eof = n_eof;
        send_flag(); send_frame(q, 1'b0); send_flag(); settle();
        vec++; if (n_abort - b_ab !== 1 || n_eof - b_eof !== 0) begin
            miss++; $display("FAIL ovf_abort: got abort %0d eof %0d want 1 0", n_abort - b_ab, n_eof - b_eof); end
        vec++; if (rx_q.size() - b_rx !== exp_n || rx_q[rx_q.size() - 1] !== exp_last) begin
            miss++; $display("FAIL ovf_octets: got %0d last %h want %0d last %h", rx_q.size() - b_rx, rx_q[rx_q.size() - 1], exp_n, exp_last); end
        vec++; if (err_counter !== 32'd5 || byte_count !== 8'd16) begin
            miss++; $display("FAIL ovf_counters: got err %0d bytes %0d want 5 16", err_counter, byte_count); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] q[$];
        int b_rx, b_ok, exp_n;
        logic [7:0] exp_last;
        send_flag(); send_byte(8'h31); send_byte(8'h32); send_sbit(1'b1); send_sbit(1'b0); send_sbit(1'b1);
        rst_n = 1'b0; @(posedge clk); #1;
        vec++; if ({dout, dout_valid, sof, eof, frame_ok, crc_err, abort, byte_count} !== 22'h0) begin
            miss++; $display("FAIL midreset_outputs: got %h want 0", {dout, dout_valid, sof, eof, frame_ok, crc_err, abort, byte_count}); end
        vec++; if (frame_counter !== 32'd0 || err_counter !== 32'd0) begin
            miss++; $display("FAIL midreset_counters: got %0d %0d want 0 0", frame_counter, err_counter); end
        rst_n = 1'b1;
        b_rx = rx_q.size(); b_ok = n_ok;
        q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
`ifdef HDLC_RX_FCS_STRIP_EN
        exp_n = 9; exp_last = 8'h39;
`else
        exp_n = 11; exp_last = 8'h90;
`endif
        send_flag(); send_frame(q, 1'b0); send_flag(); settle();
        vec++; if (n_ok - b_ok !== 1 || frame_counter !== 32'd1) begin
            miss++; $display("FAIL midreset_recover: got ok %0d frames %0d want 1 1", n_ok - b_ok, frame_counter); end
        vec++; if (rx_q.size() - b_rx !== exp_n || rx_q[b_rx] !== 8'h31 || rx_q[rx_q.size() - 1] !== exp_last) begin
            miss++; $display("FAIL midreset_octets: got %0d octets last %h want %0d last %h", rx_q.size() - b_rx, rx_q[rx_q.size() - 1], exp_n, exp_last); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_transparency();
        test_crc_err();
        test_abort();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
